// File: rtl/dds_wave_ctrl.sv
// Waveform RAM controller: streams a table into a single-port RAM, then plays it
// back through a phase accumulator as a valid-qualified DDS sample stream.
module dds_wave_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_DEPTH  = 256,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [DATA_WIDTH-1:0]         load_data_i,
  output logic                          load_done_o,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [PHASE_WIDTH-1:0]        freq_word_i,
  output logic                          ram_wea_o,
  output logic [$clog2(DATA_DEPTH)-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wr_data_o,
  input  logic [DATA_WIDTH-1:0]         ram_re_data_i,
  output logic [DATA_WIDTH-1:0]         wave_out_o,
  output logic                          wave_valid_o,
  output logic                          busy_o
);

  localparam int ADDR_W = $clog2(DATA_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] freq_q, freq_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                   ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]  ram_wr_data_q, ram_wr_data_d;
  logic [DATA_WIDTH-1:0]  wave_q, wave_d;
  logic                   wave_valid_q, wave_valid_d;
  logic                   load_done_q, load_done_d;
  // rd_pend: an address was issued last edge; re_pend: ram_re_data now holds its result.
  logic                   rd_pend_q, rd_pend_d;
  logic                   re_pend_q, re_pend_d;

  logic                   accept;
  logic [PHASE_WIDTH-1:0] phase_sum;

  assign load_ready_o = (state_q != ST_RUN);
  assign accept       = load_valid_i & load_ready_o;
  assign phase_sum    = phase_q + freq_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    freq_d        = freq_q;
    wr_ptr_d      = wr_ptr_q;
    ram_wea_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    wave_d        = wave_q;
    wave_valid_d  = 1'b0;
    load_done_d   = 1'b0;
    rd_pend_d     = 1'b0;
    re_pend_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram_wea_d     = 1'b1;
          ram_addr_d    = wr_ptr_q;
          ram_wr_data_d = load_data_i;
          wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
          state_d       = ST_LOAD;
        end else if (start_i) begin
          freq_d     = freq_word_i;
          phase_d    = '0;
          ram_addr_d = '0;
          rd_pend_d  = 1'b1;
          state_d    = ST_RUN;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          ram_wea_d     = 1'b1;
          ram_addr_d    = wr_ptr_q;
          ram_wr_data_d = load_data_i;
          wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == ADDR_W'(DATA_DEPTH - 1)) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Stop drops everything in flight; the next start replays from phase 0.
        if (stop_i) begin
          state_d = ST_IDLE;
        end else begin
          phase_d    = phase_sum;
          ram_addr_d = phase_sum[PHASE_WIDTH-1 -: ADDR_W];
          rd_pend_d  = 1'b1;
          re_pend_d  = rd_pend_q;
          if (re_pend_q) begin
            wave_d       = ram_re_data_i;
            wave_valid_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      freq_q        <= '0;
      wr_ptr_q      <= '0;
      ram_wea_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      wave_q        <= '0;
      wave_valid_q  <= 1'b0;
      load_done_q   <= 1'b0;
      rd_pend_q     <= 1'b0;
      re_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      freq_q        <= freq_d;
      wr_ptr_q      <= wr_ptr_d;
      ram_wea_q     <= ram_wea_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      wave_q        <= wave_d;
      wave_valid_q  <= wave_valid_d;
      load_done_q   <= load_done_d;
      rd_pend_q     <= rd_pend_d;
      re_pend_q     <= re_pend_d;
    end
  end

  assign ram_wea_o     = ram_wea_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wr_data_o = ram_wr_data_q;
  assign wave_out_o    = wave_q;
  assign wave_valid_o  = wave_valid_q;
  assign load_done_o   = load_done_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Bench for dds_wave_ctrl: models the waveform RAM and scoreboards the sample stream
// against samples predicted from the loaded table and the frequency word.
module tb_dds_wave_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_done;
  logic        start;
  logic        stop;
  logic [31:0] freq_word;
  logic        ram_wea;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_re_data;
  logic [7:0]  wave_out;
  logic        wave_valid;
  logic        busy;

  logic [7:0]  mem [256];
  logic [7:0]  tbl [256];
  logic [7:0]  exp_q [$];
  int          n_checks;
  int          n_fail;

  dds_wave_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(256), .PHASE_WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_data_i   (load_data),
    .load_done_o   (load_done),
    .start_i       (start),
    .stop_i        (stop),
    .freq_word_i   (freq_word),
    .ram_wea_o     (ram_wea),
    .ram_addr_o    (ram_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_re_data_i (ram_re_data),
    .wave_out_o    (wave_out),
    .wave_valid_o  (wave_valid),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addr] <= ram_wr_data;
    ram_re_data <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every valid sample must match the head of the expected queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wave_valid === 1'b1) begin
        if (exp_q.size() == 0) check_val("sb_extra_valid", wave_valid, 0);
        else check_val("sb_sample", wave_out, exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_valid"}, wave_valid, 0);
    check_val({tag, "_wave"}, wave_out, 0);
    check_val({tag, "_wea"}, ram_wea, 0);
    check_val({tag, "_addr"}, ram_addr, 0);
    check_val({tag, "_wdata"}, ram_wr_data, 0);
    check_val({tag, "_done"}, load_done, 0);
    check_val({tag, "_ready"}, load_ready, 1);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    load_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    #2;
    check_reset_vals(tag);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    $display("reset %s applied", tag);
  endtask

  task automatic load_range(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      load_valid = 1'b1;
      load_data = tbl[i];
      tick();
      check_val("ld_wea", ram_wea, 1);
      check_val("ld_addr", ram_addr, i);
      check_val("ld_wdata", ram_wr_data, tbl[i]);
      check_val("ld_done", load_done, (i == 255));
      check_val("ld_busy", busy, (i != 255));
      check_val("ld_valid", wave_valid, 0);
      if (gaps) begin
        load_valid = 1'b0;
        load_data = ~tbl[i];
        tick();
        check_val("gap_wea", ram_wea, 0);
        check_val("gap_done", load_done, 0);
        check_val("gap_busy", busy, (i != 255));
      end
    end
    load_valid = 1'b0;
    $display("load words %0d..%0d gaps=%0d", lo, hi, gaps);
  endtask

  task automatic readback();
    int bad;
    tick();
    check_val("done_pulse_end", load_done, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== tbl[i]) bad++;
    end
    check_val("readback_bad_entries", bad, 0);
    $display("readback of 256 entries, %0d differ", bad);
  endtask

  // Start at E0, stop sampled at E(nsamp+2): exactly nsamp samples emerge.
  task automatic run_seq(input logic [31:0] f, input int nsamp, input bit both);
    logic [31:0] ph;
    logic [7:0]  last;
    last = 8'h00;
    for (int n = 0; n < nsamp; n++) begin
      ph = 32'(n) * f;
      last = tbl[ph[31:24]];
      exp_q.push_back(last);
    end
    freq_word = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    freq_word = ~f;
    check_val("run_busy", busy, 1);
    check_val("run_ready", load_ready, 0);
    repeat (nsamp + 1) tick();
    stop = 1'b1;
    start = both;
    tick();
    stop = 1'b0;
    start = 1'b0;
    check_val("stop_valid", wave_valid, 0);
    check_val("stop_busy", busy, 0);
    check_val("sb_drained", exp_q.size(), 0);
    if (nsamp > 0) check_val("stop_hold", wave_out, last);
    exp_q.delete();
    $display("run freq=%08h samples=%0d start_with_stop=%0d", f, nsamp, both);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    load_valid = 1'b0;
    load_data = 8'h00;
    start = 1'b0;
    stop = 1'b0;
    freq_word = 32'h0;
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (2) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) tbl[i] = 8'((i * i) & 8'hFF);
    load_range(0, 255, 1'b0);
    readback();

    run_seq(32'h0100_0000, 258, 1'b0);
    run_seq(32'h0200_0000, 20, 1'b0);
    run_seq(32'h0000_0000, 10, 1'b0);
    run_seq(32'h0123_4567, 40, 1'b0);
    run_seq(32'h0100_0000, 10, 1'b0);
    run_seq(32'h0300_0000, 6, 1'b1);

    // stop in IDLE must not disturb anything
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("idle_stop_busy", busy, 0);
    check_val("idle_stop_valid", wave_valid, 0);

    // Reload with a new table; first word arrives together with start.
    for (int i = 0; i < 256; i++) tbl[i] = 8'((i * 5 + 1) & 8'hFF);
    load_valid = 1'b1;
    start = 1'b1;
    freq_word = 32'h0100_0000;
    load_data = tbl[0];
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    check_val("prio_busy", busy, 1);
    check_val("prio_wea", ram_wea, 1);
    check_val("prio_addr", ram_addr, 0);
    check_val("prio_ready", load_ready, 1);
    tick();
    check_val("prio_gap_wea", ram_wea, 0);
    check_val("prio_valid", wave_valid, 0);
    $display("load word 0 with start asserted");
    load_range(1, 255, 1'b1);
    readback();
    run_seq(32'h0100_0000, 20, 1'b0);

    // Reset in the middle of a run.
    freq_word = 32'h0100_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(tbl[0]);
    exp_q.push_back(tbl[1]);
    exp_q.push_back(tbl[2]);
    exp_q.push_back(tbl[3]);
    repeat (5) tick();
    check_val("pre_rst_valid", wave_valid, 1);
    check_val("pre_rst_sb", exp_q.size(), 0);
    apply_reset("mid_run");

    // Reset after 100 load words, then a complete load from address 0.
    for (int i = 0; i < 256; i++) tbl[i] = 8'((i * 7 + 3) & 8'hFF);
    load_range(0, 99, 1'b0);
    apply_reset("mid_load");
    for (int i = 0; i < 256; i++) tbl[i] = 8'((i * 11 + 9) & 8'hFF);
    load_range(0, 255, 1'b0);
    readback();
    run_seq(32'h0080_0000, 12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_wave_ctrl.md
Name: dds_wave_ctrl

Overview:
- Controller that drives the single-port waveform RAM.
- Loads a waveform table into the RAM from an upstream valid/ready stream.
- In run mode, steps a phase accumulator, turns the phase into RAM read addresses, and presents the returned samples as a valid-qualified DDS output stream.
- It is the only master of the RAM's clk-domain port: it owns wea, addr and wr_data, and consumes re_data.

Parameters:
- DATA_WIDTH, 8: sample width; equals the RAM data width.
- DATA_DEPTH, 256: RAM entries; must be a power of 2. ADDR_W = $clog2(DATA_DEPTH).
- PHASE_WIDTH, 32: phase accumulator width; must be at least ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  upstream table word available.
- load_ready  out  1  controller can accept a table word.
- load_data  in  DATA_WIDTH  table word.
- load_done  out  1  one-cycle pulse after the DATA_DEPTH-th table word is accepted.
- start  in  1  level sampled each cycle; honoured only in IDLE.
- stop  in  1  level sampled each cycle; honoured only in RUN.
- freq_word  in  PHASE_WIDTH  phase increment; latched when start is honoured.
- ram_wea  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_re_data  in  DATA_WIDTH  RAM read data; registered read, valid one clk after ram_addr with ram_wea=0.
- wave_out  out  DATA_WIDTH  synthesized sample.
- wave_valid  out  1  wave_out holds a new sample this cycle.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (async on rst_n low):
  - state=IDLE, phase=0, freq_reg=0, wr_ptr=0.
  - ram_wea=0, ram_addr=0, ram_wr_data=0.
  - wave_out=0, wave_valid=0, load_done=0, busy=0.
  - Read pipeline flag rd_pend=0.
- States: IDLE, LOAD, RUN.
- load_ready is combinational: 1 in IDLE and LOAD, 0 in RUN. An accept is load_valid & load_ready at a rising edge.
- IDLE:
  - Accept has priority over start. On accept: register ram_wea=1, ram_addr=wr_ptr, ram_wr_data=load_data, wr_ptr+=1, go to LOAD. The RAM commits the write on the following edge.
  - Else if start: freq_reg=freq_word, phase=0, ram_addr=0, ram_wea=0, rd_pend=1, go to RUN.
  - Else ram_wea=0.
- LOAD:
  - Each accept writes as in IDLE. Cycles with no accept drive ram_wea=0; gaps are allowed.
  - On the accept with wr_ptr == DATA_DEPTH-1: wr_ptr wraps to 0, go to IDLE, load_done=1 for the next cycle.
  - start is ignored in LOAD.
- RUN:
  - Every cycle: phase <= phase + freq_reg, modulo 2^PHASE_WIDTH (wrap silently).
  - ram_addr <= top ADDR_W bits of (phase + freq_reg); ram_wea=0.
  - rd_pend=1 on every cycle the controller drives a read address.
  - wave_out <= ram_re_data and wave_valid <= 1 on the edge after each read result arrives. The pipeline is ram_addr registered -> RAM registered -> wave_out registered.
  - Latency: start honoured at edge E0 -> wave_out = mem[0] with wave_valid=1 after edge E0+2. Then one new sample every cycle.
  - wave_out[n] = mem[(n*freq_reg >> (PHASE_WIDTH-ADDR_W)) mod DATA_DEPTH].
- stop in RUN: go to IDLE at that edge; rd_pend=0; in-flight samples are discarded. wave_valid=0 from the next cycle. wave_out holds its last value. Phase is not preserved; the next start restarts from 0.
- Simultaneous start+stop in RUN: stop wins. In IDLE, stop is ignored.
- freq_word changes during RUN have no effect until the next start.
- freq_reg=0: RUN outputs mem[0] continuously with wave_valid=1.
- wave_valid=0 in IDLE and LOAD.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. A partial table stays in the RAM; wr_ptr restarts at 0.

Test Plan:
- Load: stream 256 words with data = (i*i)&8'hFF, load_valid held high -> ram_wea high for 256 consecutive cycles, addresses 0..255; load_done pulses exactly once, one cycle after the last accept; a RAM readback matches.
- Load with gaps: load_valid toggling 1,0,1,0 -> ram_wea=0 in gap cycles; addresses still contiguous; state stays LOAD until word 256.
- Run step 1: freq_word=32'h0100_0000, start -> wave_valid rises 2 cycles after the start edge; wave_out = mem[0], mem[1], ..., mem[255], mem[0] (wrap), with no bubbles.
- Run step 2 and step 0: freq_word=32'h0200_0000 -> mem[0], mem[2], mem[4], ...; freq_word=0 -> mem[0] repeated. Changing freq_word mid-run does not alter the sequence.
- Stop/priority: stop after 10 samples -> wave_valid=0 the next cycle and busy=0; start+stop asserted together in RUN -> IDLE; load_valid+start together in IDLE -> LOAD entered and start ignored.
- Reset mid-operation: rst_n low during RUN and again after 100 load words -> all outputs at reset values immediately; a subsequent full load writes starting at address 0.
